// File: rtl/truth_table_sequencer_pkg.sv
// Shared definitions for the truth-table sequencer.
//   state_t : sweep controller state encoding (2 bits)
//   tt_w()  : truth-table width for a given input count (2**n)
//   CNT_W   : width of the settle counter, large enough for DWELL up to 255
package truth_table_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int CNT_W = 8;

  function automatic int tt_w(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/truth_table_sequencer_settle_timer.sv
// Settle-interval counter.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear to 0 (wins over en)
//   en       : count enable
//   cnt      : current count
//   term     : high while cnt == DWELL-1
module settle_timer
  import truth_table_sequencer_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             term
);

  assign term = (cnt == CNT_W'(DWELL - 1));

  // Counter parks on the terminal value; the controller clears it per vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             cnt <= '0;
    else if (clr)        cnt <= '0;
    else if (en && !term) cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/truth_table_sequencer.sv
// Self-test sweep controller for a small combinational datapath.
// Steps x_out through 0..2**N_IN-1, holds each vector DWELL+1 cycles,
// samples f_in at the end of each vector, then compares with exp_tt.
//   clk, rst  : clock, asynchronous active-high reset
//   start     : sweep request, accepted only in IDLE
//   f_in      : datapath output under test
//   exp_tt    : expected table, looked at in the DONE cycle only
//   x_out     : vector driven to the datapath (MSB is x1)
//   busy/done : handshake; done is a one-cycle pulse
//   tt_out    : captured table
//   pass, err_cnt, err_idx : compare result, valid from done until next start
module truth_table_sequencer
  import truth_table_sequencer_pkg::*;
#(
  parameter int N_IN  = 3,
  parameter int DWELL = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     f_in,
  input  logic [tt_w(N_IN)-1:0]    exp_tt,
  output logic [N_IN-1:0]          x_out,
  output logic                     busy,
  output logic                     done,
  output logic [tt_w(N_IN)-1:0]    tt_out,
  output logic                     pass,
  output logic [N_IN:0]            err_cnt,
  output logic [N_IN-1:0]          err_idx
);

  localparam int              TW       = tt_w(N_IN);
  localparam logic [N_IN-1:0] IDX_LAST = '1;

  state_t            state, state_nxt;
  logic [N_IN-1:0]   idx;
  logic [TW-1:0]     tt_q;
  logic              pass_q;
  logic [N_IN:0]     err_cnt_q;
  logic [N_IN-1:0]   err_idx_q;

  logic              go;
  logic              tmr_clr, tmr_en, tmr_term;
  logic [CNT_W-1:0]  tmr_cnt;

  logic [TW-1:0]     mis;
  logic              cmp_pass;
  logic [N_IN:0]     cmp_cnt;
  logic [N_IN-1:0]   cmp_idx;

  assign go = (state == IDLE) && start;

  settle_timer #(.DWELL(DWELL)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr  (tmr_clr),
    .en   (tmr_en),
    .cnt  (tmr_cnt),
    .term (tmr_term)
  );

  always_comb begin
    state_nxt = state;
    tmr_clr   = 1'b0;
    tmr_en    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SETTLE;
          tmr_clr   = 1'b1;
        end
      end
      SETTLE: begin
        tmr_en = 1'b1;
        if (tmr_term) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        tmr_clr   = 1'b1;
        state_nxt = (idx == IDX_LAST) ? DONE : SETTLE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Compare: mismatch vector, popcount, lowest set bit (scan high-to-low so
  // the last assignment is the lowest index).
  always_comb begin
    mis     = tt_q ^ exp_tt;
    cmp_pass = (mis == '0);
    cmp_cnt = '0;
    cmp_idx = '0;
    for (int i = TW - 1; i >= 0; i--) begin
      cmp_cnt = cmp_cnt + (N_IN+1)'(mis[i]);
      if (mis[i]) cmp_idx = N_IN'(i);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      tt_q      <= '0;
      pass_q    <= 1'b0;
      err_cnt_q <= '0;
      err_idx_q <= '0;
    end else begin
      state <= state_nxt;
      if (go) begin
        idx       <= '0;
        tt_q      <= '0;
        pass_q    <= 1'b0;
        err_cnt_q <= '0;
        err_idx_q <= '0;
      end else if (state == SAMPLE) begin
        tt_q[idx] <= f_in;
        if (idx != IDX_LAST) idx <= idx + 1'b1;
      end else if (state == DONE) begin
        pass_q    <= cmp_pass;
        err_cnt_q <= cmp_cnt;
        err_idx_q <= cmp_idx;
      end
    end
  end

  // In the DONE cycle the result is shown straight from the compare so it is
  // valid alongside done; it is latched on leaving DONE and held until start.
  assign x_out   = idx;
  assign tt_out  = tt_q;
  assign busy    = (state == SETTLE) || (state == SAMPLE);
  assign done    = (state == DONE);
  assign pass    = (state == DONE) ? cmp_pass : pass_q;
  assign err_cnt = (state == DONE) ? cmp_cnt  : err_cnt_q;
  assign err_idx = (state == DONE) ? cmp_idx  : err_idx_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
module tb_truth_table_sequencer;

  localparam int N_IN  = 3;
  localparam int DWELL = 4;
  localparam int TW    = 1 << N_IN;
  localparam int DC    = TW * (DWELL + 1) + 1;  // done cycle after start edge

  logic            clk = 1'b0;
  logic            rst, start, f_in;
  logic [TW-1:0]   exp_tt;
  logic [N_IN-1:0] x_out;
  logic            busy, done, pass;
  logic [TW-1:0]   tt_out;
  logic [N_IN:0]   err_cnt;
  logic [N_IN-1:0] err_idx;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  truth_table_sequencer #(.N_IN(N_IN), .DWELL(DWELL)) dut (
    .clk(clk), .rst(rst), .start(start), .f_in(f_in), .exp_tt(exp_tt),
    .x_out(x_out), .busy(busy), .done(done), .tt_out(tt_out),
    .pass(pass), .err_cnt(err_cnt), .err_idx(err_idx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int lowest(input logic [TW-1:0] v);
    for (int i = 0; i < TW; i++) if (v[i]) return i;
    return 0;
  endfunction

  // One sweep: dp is the datapath's truth table, expv the expected table.
  // Called with the DUT idle; the first edge inside accepts start.
  task automatic sweep(input logic [TW-1:0] dp, input logic [TW-1:0] expv,
                       input bit glitch, input bit repulse, input bit hold);
    logic [TW-1:0] mis;
    mis = dp ^ expv;
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    for (int k = 1; k <= DC; k++) begin
      int v;
      bit samp;
      v    = (k == DC) ? TW - 1 : (k - 1) / (DWELL + 1);
      samp = ((k % (DWELL + 1)) == 0);
      f_in = dp[v];
      if (glitch && !samp && k[0]) f_in = ~dp[v];
      exp_tt = (k == DC) ? expv : TW'($urandom());
      if (repulse && (k == 5 || k == 20)) start = 1'b1;
      else if (!hold) start = 1'b0;
      #1;
      chk("x_out", x_out, v);
      chk("busy", busy, k < DC);
      chk("done", done, k == DC);
      if (k == DC) begin
        chk("tt_out", tt_out, dp);
        chk("pass", pass, mis == '0);
        chk("err_cnt", err_cnt, $countones(mis));
        chk("err_idx", err_idx, lowest(mis));
      end
      @(posedge clk); #1;
    end
    // IDLE cycle: results held even though exp_tt moves.
    exp_tt = ~expv;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_x", x_out, TW - 1);
    chk("idle_tt", tt_out, dp);
    chk("idle_pass", pass, mis == '0);
    chk("idle_cnt", err_cnt, $countones(mis));
    chk("idle_idx", err_idx, lowest(mis));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_x"}, x_out, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_tt"}, tt_out, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_cnt"}, err_cnt, 0);
    chk({tag, "_idx"}, err_idx, 0);
  endtask

  initial begin
    logic [TW-1:0] ea;
    logic [TW-1:0] rdp, rex;
    // f = (x1 & x2) | x3 with x = {x1,x2,x3}
    for (int i = 0; i < TW; i++) ea[i] = (i[2] & i[1]) | i[0];

    rst = 1'b1; start = 1'b0; f_in = 1'b0; exp_tt = '0;
    #12;
    chk_zero("reset");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    sweep(ea, 8'hEA, 0, 0, 0);          // correct datapath
    sweep('0, 8'hEA, 0, 0, 0);          // stuck-at-0
    sweep(ea, 8'hEA, 0, 1, 0);          // start re-pulsed mid-sweep
    sweep(ea, 8'hEA, 1, 0, 0);          // glitches during SETTLE

    // start held high: back-to-back sweeps with a one-cycle IDLE gap
    sweep(ea, 8'hEA, 0, 0, 1);
    sweep(ea, 8'h6A, 0, 0, 1);
    start = 1'b0;
    @(posedge clk); #1;
    chk("hold_end_busy", busy, 0);

    // reset mid-sweep at cycle 10
    f_in = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < DC + 2; k++) begin
      chk("post_rst_done", done, 0);
      @(posedge clk); #1;
    end
    sweep(ea, 8'hEA, 0, 0, 0);

    // random datapaths / expectations
    for (int r = 0; r < 4; r++) begin
      rdp = TW'($urandom());
      rex = (r == 0) ? rdp : TW'($urandom());
      sweep(rdp, rex, r[0], 0, 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
